// File: rtl/bpu_update_unit_pkg.sv
// Shared types and constants for the branch-predictor update path.
// Holds the bpu_update_t request, the BTB entry layout and the LPHT counter rule.
package bpu_update_unit_pkg;

  localparam int BPU_PC_W        = 32;
  localparam int BPU_BTB_IDX_W   = 8;
  localparam int BPU_BHT_IDX_W   = 8;
  localparam int BPU_HIST_W      = 5;
  localparam int BPU_LPHT_IDX_W  = 8;
  localparam int BPU_BR_TYPE_W   = 2;
  localparam int BPU_BTB_TAG_W   = BPU_PC_W - BPU_BTB_IDX_W - 3;

  localparam logic [1:0] LPHT_CNT_MAX = 2'd3;
  localparam logic [1:0] LPHT_CNT_MIN = 2'd0;

  typedef struct packed {
    logic [BPU_PC_W-1:0]       pc;
    logic                      btb_update;
    logic                      bht_update;
    logic                      lpht_update;
    logic                      br_taken;
    logic                      flush;
    logic [BPU_BR_TYPE_W-1:0]  br_type;
    logic [BPU_PC_W-1:0]       br_target;
    logic [1:0]                lphr;
    logic [BPU_LPHT_IDX_W-1:0] lphr_index;
  } bpu_update_t;

  typedef struct packed {
    logic                     valid;
    logic [BPU_BTB_TAG_W-1:0] tag;
    logic [BPU_PC_W-1:0]      target;
    logic [BPU_BR_TYPE_W-1:0] br_type;
  } btb_entry_t;

  function automatic logic [1:0] lpht_next(input logic [1:0] lphr, input logic taken);
    logic [1:0] cnt;
    if (taken) cnt = (lphr == LPHT_CNT_MAX) ? LPHT_CNT_MAX : lphr + 2'd1;
    else       cnt = (lphr == LPHT_CNT_MIN) ? LPHT_CNT_MIN : lphr - 2'd1;
    return cnt;
  endfunction

  function automatic logic has_update(input bpu_update_t u);
    return u.btb_update | u.bht_update | u.lpht_update;
  endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// Request queue with two ordered push ports (a before b) and one pop port.
// The count register is one bit wider than the pointers so full and empty differ.
module bpu_update_fifo
  import bpu_update_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_a,
  input  bpu_update_t   data_a,
  input  logic          push_b,
  input  bpu_update_t   data_b,
  input  logic          pop,
  output bpu_update_t   head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  bpu_update_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_b;
  logic [CW-1:0] n_push;

  // Port b lands behind port a when both push in the same cycle.
  assign wr_ptr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;
  assign n_push   = CW'(push_a) + CW'(push_b);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + n_push - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

endmodule

// File: rtl/bpu_update_unit.sv
// Merges front-end and backend predictor updates and retires them through S1/S2 into BTB, BHT and LPHT.
// Define BPU_UPDATE_PERF_EN to add the S2 request and flush counters.
module bpu_update_unit
  import bpu_update_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BTB_IDX_W  = BPU_BTB_IDX_W,
  parameter int BHT_IDX_W  = BPU_BHT_IDX_W,
  parameter int HIST_W     = BPU_HIST_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  bpu_update_t               fe_upd_i,
  input  logic                      fe_valid_i,
  output logic                      fe_ready_o,
  input  bpu_update_t               be_upd_i,
  input  logic                      be_valid_i,
  output logic                      be_ready_o,
  output logic [BHT_IDX_W-1:0]      bht_raddr_o,
  input  logic [HIST_W-1:0]         bht_rdata_i,
  output logic                      bht_we_o,
  output logic [BHT_IDX_W-1:0]      bht_waddr_o,
  output logic [HIST_W-1:0]         bht_wdata_o,
  output logic                      lpht_we_o,
  output logic [BPU_LPHT_IDX_W-1:0] lpht_waddr_o,
  output logic [1:0]                lpht_wdata_o,
  output logic                      btb_we_o,
  output logic [BTB_IDX_W-1:0]      btb_waddr_o,
  output btb_entry_t                btb_wdata_o,
  output logic                      idle_o
`ifdef BPU_UPDATE_PERF_EN
  ,
  output logic [31:0]               perf_upd_cnt_o,
  output logic [31:0]               perf_fe_flush_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_slots;
  logic          fifo_empty;
  bpu_update_t   fifo_head;
  logic          be_push;
  logic          fe_push;
  logic          push_a;
  logic          push_b;
  bpu_update_t   data_a;
  bpu_update_t   data_b;
  logic          pop;
  logic          s1_load;
  bpu_update_t   s1_next;

  logic          s1_valid;
  bpu_update_t   s1;
  logic          s2_valid;
  bpu_update_t   s2;

  logic                 fwd_valid;
  logic [BHT_IDX_W-1:0] fwd_idx;
  logic [HIST_W-1:0]    fwd_hist;

  logic [BHT_IDX_W-1:0] s2_bht_idx;
  logic [HIST_W-1:0]    hist_old;
  logic [HIST_W-1:0]    bht_new;
  logic                 wr_en;
  logic                 bht_we;
  logic                 lpht_we;
  logic                 btb_we;
  btb_entry_t           btb_entry;
  logic                 unused_s2;

  assign free_slots = CW'(FIFO_DEPTH) - fifo_count;
  assign fifo_empty = (fifo_count == '0);

  // Readies come from the registered count and be_valid_i only, never from fe_valid_i.
  always_comb begin
    be_ready_o = (free_slots != '0);
    fe_ready_o = (free_slots >= CW'(2)) | ((free_slots == CW'(1)) & ~be_valid_i);
  end

  assign be_push = be_valid_i & be_ready_o & has_update(be_upd_i);
  assign fe_push = fe_valid_i & fe_ready_o & has_update(fe_upd_i);

  // With an empty queue the oldest new request bypasses straight into S1.
  always_comb begin
    s1_load = 1'b0;
    s1_next = be_upd_i;
    pop     = 1'b0;
    push_a  = 1'b0;
    data_a  = be_upd_i;
    push_b  = 1'b0;
    data_b  = fe_upd_i;
    if (!fifo_empty) begin
      pop     = 1'b1;
      s1_load = 1'b1;
      s1_next = fifo_head;
      push_a  = be_push;
      push_b  = fe_push;
    end else if (be_push) begin
      s1_load = 1'b1;
      s1_next = be_upd_i;
      push_a  = fe_push;
      data_a  = fe_upd_i;
    end else if (fe_push) begin
      s1_load = 1'b1;
      s1_next = fe_upd_i;
    end
  end

  bpu_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_a (push_a),
    .data_a (data_a),
    .push_b (push_b),
    .data_b (data_b),
    .pop    (pop),
    .head   (fifo_head),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      s2_valid  <= 1'b0;
      s2        <= '0;
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_hist  <= '0;
    end else begin
      s1_valid <= s1_load;
      if (s1_load) s1 <= s1_next;
      s2_valid <= s1_valid;
      if (s1_valid) s2 <= s1;
      fwd_valid <= bht_we;
      fwd_idx   <= s2_bht_idx;
      fwd_hist  <= bht_new;
    end
  end

  assign bht_raddr_o = s1.pc[BHT_IDX_W+2:3];

  // The memory read for S2 was issued while the previous S2 was writing; take that write instead.
  always_comb begin
    s2_bht_idx = s2.pc[BHT_IDX_W+2:3];
    hist_old   = (fwd_valid && fwd_idx == s2_bht_idx) ? fwd_hist : bht_rdata_i;
    bht_new    = {hist_old[HIST_W-2:0], s2.br_taken};
  end

  always_comb begin
    wr_en   = rst_n & s2_valid;
    bht_we  = wr_en & s2.bht_update;
    lpht_we = wr_en & s2.lpht_update;
    btb_we  = wr_en & s2.btb_update;

    btb_entry         = '0;
    btb_entry.valid   = 1'b1;
    btb_entry.tag     = s2.pc[BPU_PC_W-1:BTB_IDX_W+3];
    btb_entry.target  = s2.br_target;
    btb_entry.br_type = s2.br_type;

    bht_we_o     = bht_we;
    bht_waddr_o  = bht_we ? s2_bht_idx : '0;
    bht_wdata_o  = bht_we ? bht_new : '0;
    lpht_we_o    = lpht_we;
    lpht_waddr_o = lpht_we ? s2.lphr_index : '0;
    lpht_wdata_o = lpht_we ? lpht_next(s2.lphr, s2.br_taken) : 2'd0;
    btb_we_o     = btb_we;
    btb_waddr_o  = btb_we ? s2.pc[BTB_IDX_W+2:3] : '0;
    btb_wdata_o  = btb_we ? btb_entry : '0;
  end

  assign idle_o    = fifo_empty & ~s1_valid & ~s2_valid;
  assign unused_s2 = ^{s2.pc[2:0], s2.flush};

`ifdef BPU_UPDATE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_upd_cnt_o      <= '0;
      perf_fe_flush_cnt_o <= '0;
    end else begin
      if (s2_valid)             perf_upd_cnt_o      <= perf_upd_cnt_o + 32'd1;
      if (s2_valid && s2.flush) perf_fe_flush_cnt_o <= perf_fe_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_update_unit.sv
// Bench for bpu_update_unit: directed table, hand sequences, then random traffic against a queue model.
module tb_bpu_update_unit;
  import bpu_update_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bpu_update_t fe_upd, be_upd;
  logic        fe_valid = 1'b0, be_valid = 1'b0;
  logic        fe_ready, be_ready;
  logic [7:0]  bht_raddr;
  logic [4:0]  bht_rdata = 5'd0;
  logic        bht_we;
  logic [7:0]  bht_waddr;
  logic [4:0]  bht_wdata;
  logic        lpht_we;
  logic [7:0]  lpht_waddr;
  logic [1:0]  lpht_wdata;
  logic        btb_we;
  logic [7:0]  btb_waddr;
  btb_entry_t  btb_wdata;
  logic        idle;
`ifdef BPU_UPDATE_PERF_EN
  logic [31:0] perf_upd_cnt, perf_fe_flush_cnt;
`endif

  always #5 clk = ~clk;

  bpu_update_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fe_upd_i     (fe_upd),
    .fe_valid_i   (fe_valid),
    .fe_ready_o   (fe_ready),
    .be_upd_i     (be_upd),
    .be_valid_i   (be_valid),
    .be_ready_o   (be_ready),
    .bht_raddr_o  (bht_raddr),
    .bht_rdata_i  (bht_rdata),
    .bht_we_o     (bht_we),
    .bht_waddr_o  (bht_waddr),
    .bht_wdata_o  (bht_wdata),
    .lpht_we_o    (lpht_we),
    .lpht_waddr_o (lpht_waddr),
    .lpht_wdata_o (lpht_wdata),
    .btb_we_o     (btb_we),
    .btb_waddr_o  (btb_waddr),
    .btb_wdata_o  (btb_wdata),
    .idle_o       (idle)
`ifdef BPU_UPDATE_PERF_EN
    ,
    .perf_upd_cnt_o      (perf_upd_cnt),
    .perf_fe_flush_cnt_o (perf_fe_flush_cnt)
`endif
  );

  // BHT array: registered read, read-before-write on a same-cycle collision.
  logic [4:0] bht_mem [256] = '{default: 5'd0};
  always @(posedge clk) begin
    bht_rdata <= bht_mem[bht_raddr];
    if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: accepted requests wait in an ordered queue; each cycle the oldest
  // moves to stage 1, and what was in stage 1 is written the following cycle.
  bpu_update_t mq[$];
  bpu_update_t p1, p2;
  bit          p1v = 0, p2v = 0;
  logic [4:0]  ref_hist [256] = '{default: 5'd0};

  function automatic logic [1:0] ref_lpht(input logic [1:0] l, input logic taken);
    int v;
    v = int'(l) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic bit anybits(input bpu_update_t u);
    return u.btb_update || u.bht_update || u.lpht_update;
  endfunction

  task automatic model_cycle();
    int          free;
    bit          ebr, efr;
    logic [13:0] e_bht;
    logic [10:0] e_lpht;
    logic [64:0] e_btb;
    logic [7:0]  idx;
    free  = 4 - mq.size();
    ebr   = (free >= 1);
    efr   = (free >= 2) || (free == 1 && !be_valid);
    check("ready", {be_ready, fe_ready}, {ebr, efr});
    e_bht = '0; e_lpht = '0; e_btb = '0;
    if (rst_n && p2v) begin
      idx = p2.pc[10:3];
      if (p2.bht_update)  e_bht  = {1'b1, idx, ref_hist[idx][3:0], p2.br_taken};
      if (p2.lpht_update) e_lpht = {1'b1, p2.lphr_index, ref_lpht(p2.lphr, p2.br_taken)};
      if (p2.btb_update)  e_btb  = {1'b1, idx, 1'b1, p2.pc[31:11], p2.br_target, p2.br_type};
    end
    check("bht_write", {bht_we, bht_waddr, bht_wdata}, e_bht);
    check("lpht_write", {lpht_we, lpht_waddr, lpht_wdata}, e_lpht);
    check("btb_write", {btb_we, btb_waddr, btb_wdata}, e_btb);
    if (rst_n) begin
      check("idle", idle, (mq.size() == 0) && !p1v && !p2v);
      if (p1v) check("bht_raddr", bht_raddr, p1.pc[10:3]);
    end
    if (!rst_n) begin
      mq.delete();
      p1v = 0;
      p2v = 0;
    end else begin
      if (e_bht[13]) ref_hist[e_bht[12:5]] = e_bht[4:0];
      if (be_valid && ebr && anybits(be_upd)) mq.push_back(be_upd);
      if (fe_valid && efr && anybits(fe_upd)) mq.push_back(fe_upd);
      p2 = p1;
      p2v = p1v;
      p1v = (mq.size() != 0);
      if (p1v) p1 = mq.pop_front();
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bpu_update_t mk(input logic [31:0] pc, input logic [2:0] bits,
                                     input logic taken, input logic [1:0] lphr);
    bpu_update_t u;
    u.pc          = pc;
    u.btb_update  = bits[2];
    u.bht_update  = bits[1];
    u.lpht_update = bits[0];
    u.br_taken    = taken;
    u.flush       = ~taken;
    u.br_type     = 2'd1;
    u.br_target   = pc + 32'h100;
    u.lphr        = lphr;
    u.lphr_index  = pc[10:3] ^ 8'h5A;
    return u;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  bits;
    logic        taken;
    logic [1:0]  lphr;
    logic [4:0]  exp_bht;
    logic [1:0]  exp_lpht;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{32'h1C00_0010, 3'b010, 1'b1, 2'd1, 5'b00001, 2'd0};
    vt[1] = '{32'h1C00_0100, 3'b001, 1'b1, 2'd3, 5'b00000, 2'd3};
    vt[2] = '{32'h1C00_0108, 3'b001, 1'b0, 2'd0, 5'b00000, 2'd0};
    vt[3] = '{32'h1C00_0110, 3'b001, 1'b0, 2'd2, 5'b00000, 2'd1};
    vt[4] = '{32'h1C00_0118, 3'b001, 1'b1, 2'd1, 5'b00000, 2'd2};
    vt[5] = '{32'h1C00_0010, 3'b011, 1'b0, 2'd1, 5'b00010, 2'd0};
    vt[6] = '{32'h1C00_0200, 3'b100, 1'b0, 2'd2, 5'b00000, 2'd0};

    fe_upd = '0;
    be_upd = '0;
    @(posedge clk); #1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_ready", {be_ready, fe_ready}, 2'b11);
    check("rst_idle", idle, 1'b1);
    check("rst_we", {bht_we, lpht_we, btb_we}, 3'b000);
    check("rst_addr", {bht_waddr, lpht_waddr, btb_waddr, bht_raddr}, 32'd0);

    // Single be requests, writes checked two cycles after acceptance.
    for (int i = 0; i < 7; i++) begin
      be_upd = mk(vt[i].pc, vt[i].bits, vt[i].taken, vt[i].lphr);
      be_valid = 1'b1;
      step();
      be_valid = 1'b0;
      step();
      check($sformatf("vec%0d_bht_we", i), bht_we, vt[i].bits[1]);
      if (vt[i].bits[1]) check($sformatf("vec%0d_bht_data", i), bht_wdata, vt[i].exp_bht);
      check($sformatf("vec%0d_lpht_we", i), lpht_we, vt[i].bits[0]);
      if (vt[i].bits[0]) check($sformatf("vec%0d_lpht_data", i), lpht_wdata, vt[i].exp_lpht);
      check($sformatf("vec%0d_btb_we", i), btb_we, vt[i].bits[2]);
      step();
      step();
    end

    // Back-to-back updates to BHT index 5 must accumulate.
    be_upd = mk(32'h1C00_0028, 3'b010, 1'b1, 2'd0); be_valid = 1'b1;
    step();
    be_upd = mk(32'h1C00_0028, 3'b010, 1'b0, 2'd0);
    step();
    check("fwd0", {bht_we, bht_waddr, bht_wdata}, {1'b1, 8'd5, 5'b00001});
    be_upd = mk(32'h1C00_0028, 3'b010, 1'b1, 2'd0);
    step();
    check("fwd1", {bht_we, bht_waddr, bht_wdata}, {1'b1, 8'd5, 5'b00010});
    be_valid = 1'b0;
    step();
    check("fwd2", {bht_we, bht_waddr, bht_wdata}, {1'b1, 8'd5, 5'b00101});
    step(); step();

    // fe and be together: be retires first.
    be_upd = mk(32'h1C00_0088, 3'b100, 1'b1, 2'd0);
    fe_upd = mk(32'h1C00_0090, 3'b100, 1'b1, 2'd0);
    be_valid = 1'b1; fe_valid = 1'b1;
    #1;
    check("dual_ready", {be_ready, fe_ready}, 2'b11);
    step();
    be_valid = 1'b0; fe_valid = 1'b0;
    step();
    check("dual_first_be", {btb_we, btb_waddr}, {1'b1, 8'h11});
    step();
    check("dual_second_fe", {btb_we, btb_waddr}, {1'b1, 8'h12});
    step(); step();

    // Hold both valids until one slot remains.
    be_upd = mk(32'h1C00_0300, 3'b010, 1'b1, 2'd0);
    fe_upd = mk(32'h1C00_0308, 3'b010, 1'b0, 2'd0);
    be_valid = 1'b1; fe_valid = 1'b1;
    step(); step(); step();
    check("one_free_both", {be_ready, fe_ready}, 2'b10);
    be_valid = 1'b0;
    #1;
    check("one_free_fe_only", {be_ready, fe_ready}, 2'b11);
    be_valid = 1'b1;
    step();
    check("s2_busy", bht_we, 1'b1);

    // Reset with requests queued and S2 writing.
    rst_n = 1'b0; be_valid = 1'b0; fe_valid = 1'b0;
    #1;
    check("rst_cycle_no_write", {bht_we, lpht_we, btb_we}, 3'b000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("post_rst_idle%0d", i), {idle, bht_we, lpht_we, btb_we}, 4'b1000);
      step();
    end

    // Random traffic concentrated on a few indices.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      pc = $urandom;
      pc[10:3] = 8'($urandom_range(0, 3));
      be_upd = mk(pc, 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
      pc = $urandom;
      pc[10:3] = 8'($urandom_range(0, 3));
      fe_upd = mk(pc, 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
      be_valid = ($urandom_range(0, 9) < 7);
      fe_valid = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; be_valid = 1'b0; fe_valid = 1'b0;
    begin
      int budget;
      budget = 0;
      while (!idle && budget < 50) begin
        step();
        budget++;
      end
      check("drain_idle", idle, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
